// File: rtl/rom_stream_reader.sv
// Streams len words from a synchronous-read ROM (starting at address 0) through a 2-entry
// skid FIFO onto a valid/ready interface. Define ROM_STREAM_CHECKSUM_EN to add a running checksum.
module rom_stream_reader #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       len,
    output logic              rom_en,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] checksum
);

    localparam logic [31:0]     LEN_MAX_32 = 32'd1 << AWIDTH;
    localparam logic [AWIDTH:0] LEN_MAX_N  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE_N      = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH:0]     r_len_eff;
    logic [AWIDTH:0]     r_issued;
    logic [AWIDTH:0]     r_sent;
    logic [AWIDTH:0]     w_len_in;
    logic [DWIDTH-1:0]   r_fifo [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;
    logic                r_inflight;
    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_last_xfer;
    logic [2:0]          w_credit;

    // Clamp the requested length so the address counter can never wrap.
    always_comb begin
        if (len > LEN_MAX_32) begin
            w_len_in = LEN_MAX_N;
        end else begin
            w_len_in = len[AWIDTH:0];
        end
    end

    // Handshake, credit-based read issue and next-state decode.
    always_comb begin
        w_accept    = (r_state != ST_RUN) && start;
        w_pop       = out_valid && out_ready;
        w_push      = r_inflight;
        // Buffered words plus the read in flight, less the one leaving this cycle.
        w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = (r_state == ST_RUN) && (r_issued < r_len_eff) && (w_credit < 3'd2);
        w_last_xfer = w_pop && (r_sent == (r_len_eff - ONE_N));
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (w_len_in != {(AWIDTH+1){1'b0}}) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_last_xfer) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length latch and issue/sent counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_eff <= {(AWIDTH+1){1'b0}};
            r_issued  <= {(AWIDTH+1){1'b0}};
            r_sent    <= {(AWIDTH+1){1'b0}};
        end else if (w_accept) begin
            r_len_eff <= w_len_in;
            r_issued  <= {(AWIDTH+1){1'b0}};
            r_sent    <= {(AWIDTH+1){1'b0}};
        end else begin
            if (w_issue) begin
                r_issued <= r_issued + ONE_N;
            end
            if (w_pop) begin
                r_sent <= r_sent + ONE_N;
            end
        end
    end

    // Two-entry FIFO capturing ROM return data one cycle after each issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0]  <= {DWIDTH{1'b0}};
            r_fifo[1]  <= {DWIDTH{1'b0}};
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= rom_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_fifo[r_rd_ptr] : {DWIDTH{1'b0}};
    assign out_last  = out_valid && (r_sent == (r_len_eff - ONE_N));
    assign rom_en    = w_issue;
    assign rom_addr  = r_issued[AWIDTH-1:0];
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DWIDTH-1:0] r_checksum;

    // Wrapping sum of transferred words, restarted on each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= {DWIDTH{1'b0}};
        end else if (w_accept) begin
            r_checksum <= {DWIDTH{1'b0}};
        end else if (w_pop) begin
            r_checksum <= r_checksum + out_data;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = {DWIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: expected words are queued at start and
// compared on every transfer; a ROM model returns mem[i] = i+1.
module tb_rom_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] len;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int          n_checks;
    int          n_errors;
    int          exp_q[$];
    int          issued_tb;
    int          sent_tb;
    int          exp_addr;
    int          stream_sent;
    int          stream_issued;
    int          ready_mode;
    logic        prev_stall;
    logic        prev_last;
    logic [31:0] prev_data;
    logic [7:0]  ready_pat;

    rom_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM model, one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'(rom_addr) + 32'd1;
    end

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Consumer readiness: always, fixed pattern 1,0,0,1,0,1,1,0, or random.
    initial begin
        int pidx;
        pidx      = 0;
        ready_pat = 8'b0110_1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ready_pat[pidx];
                    pidx      = (pidx + 1) % 8;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop, stall stability, address sequence and credit limit.
    always @(negedge clk) begin
        logic pop;
        int   exp_w;
        if (!rst_n) begin
            issued_tb  = sent_tb;
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            pop = out_valid && out_ready;
            if (start && !busy) begin
                exp_addr      = 0;
                stream_sent   = 0;
                stream_issued = 0;
            end
            if (prev_last) check_val("done_after_last", longint'(done), 1);
            if (prev_stall) begin
                check_val("stall_valid", longint'(out_valid), 1);
                check_val("stall_data", longint'(out_data), longint'(prev_data));
            end
            if (rom_en) begin
                check_val("rom_addr", longint'(rom_addr), longint'(exp_addr));
                check_val("credit", longint'((issued_tb - sent_tb - int'(pop)) < 2), 1);
                exp_addr++;
                issued_tb++;
                stream_issued++;
            end
            if (out_valid) check_val("valid_expected", longint'(exp_q.size() > 0), 1);
            prev_last = 1'b0;
            if (pop && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check_val("out_data", longint'(out_data), longint'(exp_w));
                check_val("out_last", longint'(out_last), longint'(exp_q.size() == 0));
                prev_last = (exp_q.size() == 0);
                sent_tb++;
                stream_sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic do_start(input int unsigned l);
        int unsigned eff;
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = l;
        eff   = (l > 32'd1024) ? 32'd1024 : l;
        for (int i = 0; i < int'(eff); i++) exp_q.push_back(i + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_ignored_start(input int unsigned l);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cnt;
        cnt = 0;
        while (!(done && !busy && exp_q.size() == 0) && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check_val("done_within_budget", longint'(cnt < budget), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val(tag, longint'({out_valid, out_last, rom_en, busy, done}), 0);
        check_val(tag, longint'(rom_addr), 0);
        check_val(tag, longint'(out_data), 0);
        check_val(tag, longint'(checksum), 0);
    endtask

    initial begin
        int budget;
        n_checks   = 0;
        n_errors   = 0;
        issued_tb  = 0;
        sent_tb    = 0;
        exp_addr   = 0;
        ready_mode = 0;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 32'd0;
        start      = 1'b0;
        len        = 32'd0;
        rst_n      = 1'b0;
        #1;
        check_zero_outputs("reset_outputs");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // len=4, always ready: latency and back-to-back words.
        do_start(32'd4);
        @(negedge clk);
        check_val("t1_first_rom_en", longint'(rom_en), 1);
        check_val("t1_first_addr", longint'(rom_addr), 0);
        check_val("t1_valid_early0", longint'(out_valid), 0);
        @(negedge clk);
        check_val("t1_valid_early1", longint'(out_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_val("t1_valid", longint'(out_valid), 1);
            check_val("t1_data", longint'(out_data), longint'(i));
            check_val("t1_last", longint'(out_last), longint'(i == 4));
        end
        @(negedge clk);
        check_val("t1_done", longint'(done), 1);
        check_val("t1_issued", longint'(stream_issued), 4);
`ifdef ROM_STREAM_CHECKSUM_EN
        check_val("t1_checksum", longint'(checksum), 10);
`else
        check_val("t1_checksum", longint'(checksum), 0);
`endif

        // len=16 with the fixed backpressure pattern.
        ready_mode = 1;
        do_start(32'd16);
        wait_done(400);
        check_val("t2_count", longint'(stream_sent), 16);
        ready_mode = 0;

        // len=0 goes straight to DONE without any activity.
        do_start(32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("t3_zero_done", longint'(done), 1);
            check_val("t3_zero_quiet", longint'({out_valid, rom_en, busy}), 0);
        end

        // len=5000 clamps to 1024 words.
        do_start(32'd5000);
        wait_done(3000);
        check_val("t3_clamp_sent", longint'(stream_sent), 1024);
        check_val("t3_clamp_issued", longint'(stream_issued), 1024);
        check_val("t3_last_addr", longint'(exp_addr - 1), 1023);

        // Start during RUN is ignored; then restart from DONE.
        do_start(32'd8);
        repeat (3) @(negedge clk);
        pulse_ignored_start(32'd3);
        wait_done(200);
        check_val("t4_count8", longint'(stream_sent), 8);
        do_start(32'd2);
        @(negedge clk);
        check_val("t4_done_drop", longint'(done), 0);
        check_val("t4_busy", longint'(busy), 1);
        wait_done(200);
        check_val("t4_count2", longint'(stream_sent), 2);

        // Reset after 3 words of a len=10 stream.
        do_start(32'd10);
        budget = 0;
        while (stream_sent < 3 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check_val("t5_reach3", longint'(budget < 100), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t5_reset_outputs");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("t5_quiet", longint'({out_valid, busy, done}), 0);
        end
        do_start(32'd3);
        wait_done(200);
        check_val("t5_count3", longint'(stream_sent), 3);

        // len=1024 with random readiness; checksum of 1..1024.
        ready_mode = 2;
        do_start(32'd1024);
        wait_done(20000);
        check_val("t6_count", longint'(stream_sent), 1024);
`ifdef ROM_STREAM_CHECKSUM_EN
        check_val("t6_checksum", longint'(checksum), 524800);
        @(negedge clk);
        check_val("t6_checksum_hold", longint'(checksum), 524800);
`else
        check_val("t6_checksum", longint'(checksum), 0);
        @(negedge clk);
        check_val("t6_checksum_hold", longint'(checksum), 0);
`endif
        check_val("t6_done_hold", longint'(done), 1);
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream fetch stage for the streaming accumulator path.
- On a start pulse, reads `len` consecutive words from a synchronous-read ROM (1-cycle read latency) starting at address 0.
- Presents the words as a valid/ready stream with full backpressure support.
- Never drops, duplicates or reorders words; sustains 1 word/cycle when the consumer is always ready.

Parameters:
- AWIDTH, 10, ROM address width; maximum stream length is 2^AWIDTH words.
- DWIDTH, 32, ROM/stream data width.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new stream; sampled only in IDLE and DONE.
- len  in  32  number of words to stream; sampled on the accepted start.
- rom_en  out  1  ROM read enable; high only on read-issue cycles.
- rom_addr  out  AWIDTH  ROM read address.
- rom_data  in  DWIDTH  ROM output; valid the cycle after a read is issued.
- out_data  out  DWIDTH  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready; transfer when out_valid & out_ready.
- out_last  out  1  high with the final word of the stream.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next accepted start.
- checksum  out  DWIDTH  see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; buffer empty; counters 0; discard in-flight read.
  - Outputs during reset: out_valid=0, out_last=0, rom_en=0, rom_addr=0, busy=0, done=0, checksum=0, out_data=0.
- Effective length: len_eff = min(len, 2^AWIDTH), latched on the accepted start. The address therefore never wraps.
- State machine:
  - IDLE: start=1 and len_eff>0 -> RUN. start=1 and len_eff=0 -> DONE; no words emitted.
  - RUN: -> DONE on the edge where the last word transfers (sent count reaches len_eff).
  - DONE: start=1 -> behaves exactly as from IDLE. Latch the new len, clear counters and checksum.
  - start is ignored while in RUN.
- Counters (each AWIDTH+1 bits):
  - issued: reads issued; rom_addr = issued[AWIDTH-1:0].
  - sent: words transferred out.
- Buffer: a 2-entry FIFO holds ROM return data. inflight=1 in the cycle after a read issue.
- Read issue (combinational, RUN only): rom_en = (issued < len_eff) && (count + inflight - pop < 2).
  - pop = out_valid & out_ready.
  - This credit rule guarantees no buffer overflow.
- ROM return: when inflight=1, push rom_data into the FIFO at the clock edge ending that cycle.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - out_data must remain stable while out_valid & !out_ready.
  - out_last = out_valid && (sent == len_eff-1).
- Latency: start sampled at edge E0 -> rom_en=1, addr 0 during the following cycle -> out_valid rises after edge E2.
- Throughput: with out_ready held high, subsequent words appear on consecutive cycles.
- Simultaneous push and pop on a full-credit cycle is legal; FIFO count is unchanged.
- done rises the cycle after the last transfer. busy=1 exactly while in RUN.
- Reset mid-stream: returns immediately to the reset state. The next start begins again at address 0.

Optional Feature:
- Macro: ROM_STREAM_CHECKSUM_EN.
- With the macro defined:
  - checksum is a DWIDTH-bit wrapping sum of every transferred word.
  - It is cleared on the accepted start and is final and stable whenever done=1.
- Without the macro: checksum is tied to 0 and no adder is synthesised.

Test Plan:
- ROM mem[i]=i+1, len=4, out_ready=1, start pulse at E0:
  - out_valid rises after E2; out_data = 1,2,3,4 on 4 consecutive cycles.
  - out_last high only with 4; done=1 the next cycle; rom_addr issues 0..3 once each.
- Same ROM, len=16, out_ready pattern 1,0,0,1,0,1,1,0 repeating:
  - exactly 16 transfers, values 1..16 in order.
  - out_data stable during stalls; rom_en never issues when 2 credits are in use.
- len=0 -> DONE the cycle after start; out_valid, rom_en and busy never assert. len=5000 -> exactly 1024 words; last rom_addr=1023; out_last on word 1024.
- start pulsed during RUN (len=8) -> ignored; stream of 8 completes. Then start with len=2 from DONE -> done drops, 2 words from address 0, done re-asserts.
- rst_n low for 1 cycle after 3 words of a len=10 stream:
  - all outputs zero immediately, with no further out_valid.
  - a new start with len=3 yields 1,2,3.
- ROM_STREAM_CHECKSUM_EN defined, mem[i]=i+1, len=1024, random out_ready -> checksum=524800 when done=1. Macro undefined -> checksum=0 throughout.
